// File: rtl/ex_mem_stage.sv
// ex_mem_stage: registered execute-to-memory boundary.
//
// Captures the ALU result, the EX control bundle and the store data into a
// 2-entry skid buffer (main + skid). It also resolves conditional branches
// from the incoming ALU flags (flags are from A-B) and issues a one-cycle
// redirect to fetch.
//
// Ports:
//   clk, rst                      clock (rising edge), sync active-high reset
//   in_valid / in_ready           upstream handshake (in_ready is a register)
//   alu_result, alu_z/n/v/c       ALU result and flags
//   write_data, rd, reg_write,
//   mem_write, result_src         EX payload / control bundle
//   branch, jump, funct3          branch resolution inputs
//   pc_target, pc_plus4           redirect target / link value
//   flush                         kill held and incoming entries
//   out_valid / out_ready         downstream handshake
//   out_*                         registered payload toward memory stage
//   redirect_valid, redirect_pc   one-cycle redirect pulse to fetch
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_v,
    input  logic              alu_c,
    input  logic [DATA_W-1:0] write_data,
    input  logic [REG_AW-1:0] rd,
    input  logic              reg_write,
    input  logic              mem_write,
    input  logic [1:0]        result_src,
    input  logic              branch,
    input  logic              jump,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] pc_target,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_write_data,
    output logic [DATA_W-1:0] out_pc_plus4,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write,
    output logic              out_mem_write,
    output logic [1:0]        out_result_src,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] pc4;
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic              mw;
        logic [1:0]        rs;
    } ent_t;

    ent_t              main_q, main_d, skid_q, skid_d, in_ent;
    logic              main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic              rdr_vld_q, rdr_vld_d;
    logic [DATA_W-1:0] rdr_pc_q, rdr_pc_d;
    logic              accept, consume, cond, taken;

    assign in_ent = '{result: alu_result, wdata: write_data, pc4: pc_plus4,
                      rd: rd, rw: reg_write, mw: mem_write, rs: result_src};

    // Flags come from A-B: C=1 means no borrow (A >= B unsigned).
    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = alu_z;
            3'b001:  cond = !alu_z;
            3'b100:  cond = alu_n ^ alu_v;
            3'b101:  cond = !(alu_n ^ alu_v);
            3'b110:  cond = !alu_c;
            3'b111:  cond = alu_c;
            default: cond = 1'b0;
        endcase
    end

    assign taken   = jump | (branch & cond);
    assign accept  = in_valid & in_ready;
    assign consume = main_vld_q & out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        rdr_pc_d   = rdr_pc_q;
        // Dropped instructions (flush) never redirect; a pulse already
        // on the wire simply expires after its cycle.
        rdr_vld_d  = accept & taken & !flush;
        if (rdr_vld_d) rdr_pc_d = pc_target;

        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            // FULL: in_ready is low, so only a consume can happen.
            if (consume) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (main_vld_q) begin
            if (accept && consume) begin
                main_d = in_ent;
            end else if (accept) begin
                skid_d     = in_ent;
                skid_vld_d = 1'b1;
            end else if (consume) begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            main_d     = in_ent;
            main_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdr_vld_q  <= 1'b0;
            rdr_pc_q   <= '0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdr_vld_q  <= rdr_vld_d;
            rdr_pc_q   <= rdr_pc_d;
        end
    end

    // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
    assign in_ready       = !skid_vld_q;
    assign out_valid      = main_vld_q;
    assign out_result     = main_q.result;
    assign out_write_data = main_q.wdata;
    assign out_pc_plus4   = main_q.pc4;
    assign out_rd         = main_q.rd;
    assign out_reg_write  = main_q.rw & main_vld_q;
    assign out_mem_write  = main_q.mw & main_vld_q;
    assign out_result_src = main_q.rs;
    assign redirect_valid = rdr_vld_q;
    assign redirect_pc    = rdr_pc_q;

endmodule
